// File: rtl/getir_istek_denetleyici_pkg.sv
// Shared definitions for the fetch request sequencer.
// Holds the default widths/depths used by getir_istek_denetleyici and the
// FSM state encoding. Imported by the top and its FIFO sub-module.
package getir_istek_denetleyici_pkg;

    localparam int PS_BIT_VARSAYILAN          = 32;
    localparam int BUYRUK_BIT_VARSAYILAN      = 32;
    localparam int MAKS_BEKLEYEN_VARSAYILAN   = 2;
    localparam int TAMPON_DERINLIK_VARSAYILAN = 2;

    // Address-phase FSM. The encodings are fixed so traces from older
    // benches decode the same way.
    typedef enum logic [1:0] {
        BOSTA       = 2'd0,   // no address presented to l1b
        ADRES_BEKLE = 2'd1,   // address presented, waiting for kabul
        ADRES_IPTAL = 2'd2    // address presented, but already flushed
    } durum_t;

endpackage

// File: rtl/getir_istek_denetleyici_kucuk_fifo.sv
// Small synchronous FIFO used twice by getir_istek_denetleyici.
// DERINLIK must be a power of two (>= 2): pointers carry one extra bit so
// full and empty can be told apart.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (pointers only)
//   temizle_i       drop every entry (has priority over push/pop)
//   bayrak_kur_i    when BAYRAK_VAR=1, set bit 0 of every stored entry
//   yaz_i, veri_i   push (ignored when full)
//   oku_i           pop head (ignored when empty)
//   veri_o          head entry
//   bos_o           FIFO empty
//   sayi_o          number of stored entries
module getir_istek_denetleyici_kucuk_fifo
    import getir_istek_denetleyici_pkg::*;
#(
    parameter int GENISLIK   = 8,
    parameter int DERINLIK   = 2,
    parameter bit BAYRAK_VAR = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              temizle_i,
    input  logic                              bayrak_kur_i,
    input  logic                              yaz_i,
    input  logic [GENISLIK-1:0]               veri_i,
    input  logic                              oku_i,
    output logic [GENISLIK-1:0]               veri_o,
    output logic                              bos_o,
    output logic [$clog2(DERINLIK):0]         sayi_o
);

    localparam int IB = $clog2(DERINLIK);
    localparam int SB = IB + 1;

    logic [GENISLIK-1:0] bellek [DERINLIK];
    logic [SB-1:0]       yaz_isr_q;
    logic [SB-1:0]       oku_isr_q;
    logic                dolu;
    logic                yaz_gecerli;
    logic                oku_gecerli;

    assign sayi_o      = yaz_isr_q - oku_isr_q;
    assign bos_o       = (sayi_o == '0);
    assign dolu        = (sayi_o == SB'(DERINLIK));
    assign yaz_gecerli = yaz_i & ~dolu;
    assign oku_gecerli = oku_i & ~bos_o;
    assign veri_o      = bellek[oku_isr_q[IB-1:0]];

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            yaz_isr_q <= '0;
            oku_isr_q <= '0;
        end else if (temizle_i) begin
            yaz_isr_q <= '0;
            oku_isr_q <= '0;
        end else begin
            if (yaz_gecerli) yaz_isr_q <= yaz_isr_q + SB'(1);
            if (oku_gecerli) oku_isr_q <= oku_isr_q + SB'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are live, so resetting the data would only cost flops.
    always_ff @(posedge clk_i) begin
        if (yaz_gecerli) bellek[yaz_isr_q[IB-1:0]] <= veri_i;
        // Placed after the write so the flag also lands on an entry pushed
        // in the same cycle.
        if (BAYRAK_VAR && bayrak_kur_i) begin
            for (int i = 0; i < DERINLIK; i++) bellek[i][0] <= 1'b1;
        end
    end

endmodule

// File: rtl/getir_istek_denetleyici.sv
// Fetch-stage request sequencer between getir and the L1 instruction cache.
// Accepts PS requests from getir, issues aligned addresses to l1b with a
// valid/kabul handshake, tracks up to MAKS_BEKLEYEN outstanding requests and
// returns the words to getir in order, each tagged with its original PS.
// bosalt_i discards everything in flight.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   getir_istek_gecerli_i/_hazir_o      request handshake, PS on getir_ps_i
//   bosalt_i                            redirect/flush
//   l1b_adres_o/_gecerli_o/_kabul_i     address handshake toward l1b
//   l1b_buy_i, l1b_gecerli_i            in-order word return (no back-pressure)
//   getir_buy_o/_ps_o/_gecerli_o        buffered response toward getir
//   getir_hazir_i                       getir consumes the head
//   hata_o                              sticky: word returned with nothing in flight
module getir_istek_denetleyici
    import getir_istek_denetleyici_pkg::*;
#(
    parameter int PS_BIT          = PS_BIT_VARSAYILAN,
    parameter int BUYRUK_BIT      = BUYRUK_BIT_VARSAYILAN,
    parameter int MAKS_BEKLEYEN   = MAKS_BEKLEYEN_VARSAYILAN,
    parameter int TAMPON_DERINLIK = TAMPON_DERINLIK_VARSAYILAN
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  getir_istek_gecerli_i,
    input  logic [PS_BIT-1:0]     getir_ps_i,
    output logic                  getir_istek_hazir_o,
    input  logic                  bosalt_i,
    output logic [PS_BIT-1:0]     l1b_adres_o,
    output logic                  l1b_adres_gecerli_o,
    input  logic                  l1b_adres_kabul_i,
    input  logic [BUYRUK_BIT-1:0] l1b_buy_i,
    input  logic                  l1b_gecerli_i,
    output logic [BUYRUK_BIT-1:0] getir_buy_o,
    output logic [PS_BIT-1:0]     getir_buy_ps_o,
    output logic                  getir_buy_gecerli_o,
    input  logic                  getir_hazir_i,
    output logic                  hata_o
);

    localparam int BSB = $clog2(MAKS_BEKLEYEN) + 1;
    localparam int TSB = $clog2(TAMPON_DERINLIK) + 1;

    // iptal sits in bit 0 so the FIFO's flag-set-all can mark entries stale.
    typedef struct packed {
        logic [PS_BIT-1:0] ps;
        logic              iptal;
    } bekleyen_t;

    typedef struct packed {
        logic [BUYRUK_BIT-1:0] buy;
        logic [PS_BIT-1:0]     ps;
    } yanit_t;

    durum_t            durum_q, durum_d;
    logic [PS_BIT-1:0] ps_q;
    logic              calisiyor_q;
    logic              hata_q;
    logic [BSB-1:0]    gecerli_bek_q;

    logic              kredi;
    logic              istek_kabul;
    logic              bek_yaz;
    logic              bek_iptal;
    bekleyen_t         bek_giris;
    bekleyen_t         bek_bas;
    logic              bek_bos;
    logic [BSB-1:0]    bek_sayi;
    logic              bek_gecerli_cikis;

    yanit_t            tampon_giris;
    yanit_t            tampon_bas;
    logic              tampon_bos;
    logic [TSB-1:0]    tampon_sayi;
    logic              tampon_yaz;
    logic              tampon_oku;

    // Credit uses registered counts only, so it is conservative by one
    // cycle but never lets the response buffer overflow; that is what allows
    // l1b_gecerli_i to arrive without back-pressure.
    assign kredi =
        ((int'(bek_sayi) + int'(durum_q != BOSTA)) < MAKS_BEKLEYEN) &&
        ((int'(gecerli_bek_q) + int'(durum_q == ADRES_BEKLE) + int'(tampon_sayi))
            < TAMPON_DERINLIK);

    // calisiyor_q keeps hazir low during reset and for the first edge after it.
    assign getir_istek_hazir_o = calisiyor_q & ~bosalt_i & kredi &
        ((durum_q == BOSTA) | ((durum_q == ADRES_BEKLE) & l1b_adres_kabul_i));
    assign istek_kabul = getir_istek_gecerli_i & getir_istek_hazir_o;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        durum_d   = durum_q;
        bek_yaz   = 1'b0;
        bek_iptal = 1'b0;
        unique case (durum_q)
            BOSTA: begin
                if (istek_kabul) durum_d = ADRES_BEKLE;
            end
            ADRES_BEKLE: begin
                if (l1b_adres_kabul_i) begin
                    bek_yaz   = 1'b1;
                    bek_iptal = bosalt_i;
                    durum_d   = istek_kabul ? ADRES_BEKLE : BOSTA;
                end else if (bosalt_i) begin
                    // Valid cannot be withdrawn; keep presenting the address
                    // and remember its word must be discarded.
                    durum_d = ADRES_IPTAL;
                end
            end
            ADRES_IPTAL: begin
                if (l1b_adres_kabul_i) begin
                    bek_yaz   = 1'b1;
                    bek_iptal = 1'b1;
                    durum_d   = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q     <= BOSTA;
            ps_q        <= '0;
            calisiyor_q <= 1'b0;
            hata_q      <= 1'b0;
        end else begin
            durum_q     <= durum_d;
            calisiyor_q <= 1'b1;
            if (istek_kabul) ps_q <= getir_ps_i;
            if (l1b_gecerli_i && bek_bos) hata_q <= 1'b1;
        end
    end

    // Number of in-flight entries whose word will still be delivered.
    // A flush turns every entry stale and any push that cycle is stale too.
    assign bek_gecerli_cikis = l1b_gecerli_i & ~bek_bos & ~bek_bas.iptal;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gecerli_bek_q <= '0;
        end else if (bosalt_i) begin
            gecerli_bek_q <= '0;
        end else begin
            gecerli_bek_q <= gecerli_bek_q
                           + BSB'(bek_yaz & ~bek_iptal)
                           - BSB'(bek_gecerli_cikis);
        end
    end

    assign bek_giris = '{ps: ps_q, iptal: bek_iptal};

    getir_istek_denetleyici_kucuk_fifo #(
        .GENISLIK   ($bits(bekleyen_t)),
        .DERINLIK   (MAKS_BEKLEYEN),
        .BAYRAK_VAR (1'b1)
    ) u_bekleyen (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .temizle_i    (1'b0),
        .bayrak_kur_i (bosalt_i),
        .yaz_i        (bek_yaz),
        .veri_i       (bek_giris),
        .oku_i        (l1b_gecerli_i),
        .veri_o       (bek_bas),
        .bos_o        (bek_bos),
        .sayi_o       (bek_sayi)
    );

    assign tampon_giris = '{buy: l1b_buy_i, ps: bek_bas.ps};
    assign tampon_yaz   = bek_gecerli_cikis & ~bosalt_i;
    assign tampon_oku   = getir_hazir_i & ~tampon_bos & ~bosalt_i;

    getir_istek_denetleyici_kucuk_fifo #(
        .GENISLIK   ($bits(yanit_t)),
        .DERINLIK   (TAMPON_DERINLIK),
        .BAYRAK_VAR (1'b0)
    ) u_tampon (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .temizle_i    (bosalt_i),
        .bayrak_kur_i (1'b0),
        .yaz_i        (tampon_yaz),
        .veri_i       (tampon_giris),
        .oku_i        (tampon_oku),
        .veri_o       (tampon_bas),
        .bos_o        (tampon_bos),
        .sayi_o       (tampon_sayi)
    );

    assign l1b_adres_o         = {ps_q[PS_BIT-1:2], 2'b00};
    assign l1b_adres_gecerli_o = (durum_q != BOSTA);

    // Data is forced to zero while empty so unwritten storage never shows.
    assign getir_buy_gecerli_o = ~tampon_bos;
    assign getir_buy_o         = tampon_bos ? '0 : tampon_bas.buy;
    assign getir_buy_ps_o      = tampon_bos ? '0 : tampon_bas.ps;
    assign hata_o              = hata_q;

endmodule

// File: tb/tb_getir_istek_denetleyici.sv
// Directed bench for getir_istek_denetleyici: a scoreboard queue holds the
// words getir should receive, pushed when the l1b word is driven and popped
// when getir consumes the head.
module tb_getir_istek_denetleyici;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        getir_istek_gecerli_i;
    logic [31:0] getir_ps_i;
    logic        getir_istek_hazir_o;
    logic        bosalt_i;
    logic [31:0] l1b_adres_o;
    logic        l1b_adres_gecerli_o;
    logic        l1b_adres_kabul_i;
    logic [31:0] l1b_buy_i;
    logic        l1b_gecerli_i;
    logic [31:0] getir_buy_o;
    logic [31:0] getir_buy_ps_o;
    logic        getir_buy_gecerli_o;
    logic        getir_hazir_i;
    logic        hata_o;

    typedef struct {
        logic [31:0] buy;
        logic [31:0] ps;
    } beklenen_t;

    beklenen_t beklenenler[$];
    int        checks   = 0;
    int        failures = 0;

    getir_istek_denetleyici dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .getir_istek_gecerli_i (getir_istek_gecerli_i),
        .getir_ps_i            (getir_ps_i),
        .getir_istek_hazir_o   (getir_istek_hazir_o),
        .bosalt_i              (bosalt_i),
        .l1b_adres_o           (l1b_adres_o),
        .l1b_adres_gecerli_o   (l1b_adres_gecerli_o),
        .l1b_adres_kabul_i     (l1b_adres_kabul_i),
        .l1b_buy_i             (l1b_buy_i),
        .l1b_gecerli_i         (l1b_gecerli_i),
        .getir_buy_o           (getir_buy_o),
        .getir_buy_ps_o        (getir_buy_ps_o),
        .getir_buy_gecerli_o   (getir_buy_gecerli_o),
        .getir_hazir_i         (getir_hazir_i),
        .hata_o                (hata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string etiket, input logic [63:0] gozlenen,
                       input logic [63:0] beklenen);
        checks++;
        assert (gozlenen === beklenen) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", etiket, gozlenen, beklenen);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tik();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] hizala(input logic [31:0] p);
        return {p[31:2], 2'b00};
    endfunction

    task automatic bekle_it(input logic [31:0] buy, input logic [31:0] ps);
        beklenen_t e;
        e.buy = buy;
        e.ps  = ps;
        beklenenler.push_back(e);
    endtask

    // Compare the current head against the oldest expected word.
    task automatic bas_karsilastir(input string etiket);
        beklenen_t e;
        chk({etiket, "_kuyruk_dolu"}, 64'(beklenenler.size() != 0), 64'd1);
        if (beklenenler.size() != 0) begin
            e = beklenenler.pop_front();
            chk({etiket, "_gecerli"}, 64'(getir_buy_gecerli_o), 64'd1);
            chk({etiket, "_buy"}, 64'(getir_buy_o), 64'(e.buy));
            chk({etiket, "_ps"}, 64'(getir_buy_ps_o), 64'(e.ps));
        end
    endtask

    // Wait (bounded) for a word, consume it for one cycle and compare.
    task automatic teslim_al(input string etiket);
        for (int i = 0; i < 20; i++) begin
            if (getir_buy_gecerli_o) break;
            tik();
        end
        chk({etiket, "_zamaninda"}, 64'(getir_buy_gecerli_o), 64'd1);
        if (getir_buy_gecerli_o) begin
            getir_hazir_i = 1'b1;
            #1;
            bas_karsilastir(etiket);
            tik();
            getir_hazir_i = 1'b0;
        end
    endtask

    // Two back-to-back accepted requests with kabul held high; ends in BOSTA
    // with both in flight.
    task automatic iki_istek(input string etiket, input logic [31:0] a,
                             input logic [31:0] b);
        l1b_adres_kabul_i     = 1'b1;
        getir_istek_gecerli_i = 1'b1;
        getir_ps_i            = a;
        #1;
        chk({etiket, "_hazir_a"}, 64'(getir_istek_hazir_o), 64'd1);
        tik();
        getir_ps_i = b;
        #1;
        chk({etiket, "_hazir_b"}, 64'(getir_istek_hazir_o), 64'd1);
        chk({etiket, "_adres_a"}, 64'(l1b_adres_o), 64'(hizala(a)));
        tik();
        getir_istek_gecerli_i = 1'b0;
        #1;
        chk({etiket, "_adres_b"}, 64'(l1b_adres_o), 64'(hizala(b)));
        tik();
        l1b_adres_kabul_i = 1'b0;
    endtask

    initial begin
        rst_ni                = 1'b0;
        getir_istek_gecerli_i = 1'b0;
        getir_ps_i            = '0;
        bosalt_i              = 1'b0;
        l1b_adres_kabul_i     = 1'b0;
        l1b_buy_i             = '0;
        l1b_gecerli_i         = 1'b0;
        getir_hazir_i         = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk_i);
        #1;
        chk("sifirlama_bayraklar",
            64'({getir_istek_hazir_o, l1b_adres_gecerli_o, getir_buy_gecerli_o, hata_o}), 64'd0);
        chk("sifirlama_adres", 64'(l1b_adres_o), 64'd0);
        chk("sifirlama_buy", 64'({getir_buy_o, getir_buy_ps_o}), 64'd0);
        #2 rst_ni = 1'b1;
        tik();
        tik();

        // ---- 1: single fetch ----
        getir_istek_gecerli_i = 1'b1;
        getir_ps_i            = 32'h0000_1002;
        #1;
        chk("t1_hazir", 64'(getir_istek_hazir_o), 64'd1);
        tik();
        getir_istek_gecerli_i = 1'b0;
        #1;
        chk("t1_adres_gecerli", 64'(l1b_adres_gecerli_o), 64'd1);
        chk("t1_adres", 64'(l1b_adres_o), 64'h1000);
        l1b_adres_kabul_i = 1'b1;
        tik();
        l1b_adres_kabul_i = 1'b0;
        #1;
        chk("t1_adres_birakildi", 64'(l1b_adres_gecerli_o), 64'd0);
        tik();
        l1b_gecerli_i = 1'b1;
        l1b_buy_i     = 32'h00A0_0093;
        bekle_it(32'h00A0_0093, 32'h0000_1002);
        #1;
        chk("t1_henuz_yok", 64'(getir_buy_gecerli_o), 64'd0);
        tik();
        l1b_gecerli_i = 1'b0;
        #1;
        chk("t1_bir_cevrim_sonra", 64'(getir_buy_gecerli_o), 64'd1);
        teslim_al("t1");

        // ---- 2: back-to-back, third request stalls until getir pops ----
        l1b_adres_kabul_i     = 1'b1;
        getir_istek_gecerli_i = 1'b1;
        getir_ps_i            = 32'h0;
        #1;
        chk("t2_hazir_0", 64'(getir_istek_hazir_o), 64'd1);
        tik();
        getir_ps_i = 32'h4;
        #1;
        chk("t2_hazir_4", 64'(getir_istek_hazir_o), 64'd1);
        chk("t2_adres_0", 64'(l1b_adres_o), 64'h0);
        tik();
        getir_ps_i = 32'h8;
        #1;
        chk("t2_ucuncu_durur", 64'(getir_istek_hazir_o), 64'd0);
        chk("t2_adres_4", 64'(l1b_adres_o), 64'h4);
        tik();
        l1b_gecerli_i = 1'b1;
        l1b_buy_i     = 32'h0000_0013;
        bekle_it(32'h0000_0013, 32'h0);
        #1;
        chk("t2_durur_d", 64'(getir_istek_hazir_o), 64'd0);
        tik();
        l1b_buy_i = 32'h0040_0113;
        bekle_it(32'h0040_0113, 32'h4);
        #1;
        chk("t2_durur_e", 64'(getir_istek_hazir_o), 64'd0);
        tik();
        l1b_gecerli_i = 1'b0;
        #1;
        chk("t2_durur_f", 64'(getir_istek_hazir_o), 64'd0);
        chk("t2_tampon_dolu", 64'(getir_buy_gecerli_o), 64'd1);
        tik();
        getir_hazir_i = 1'b1;
        #1;
        bas_karsilastir("t2_w0");
        chk("t2_durur_g", 64'(getir_istek_hazir_o), 64'd0);
        tik();
        #1;
        chk("t2_ucuncu_kabul", 64'(getir_istek_hazir_o), 64'd1);
        bas_karsilastir("t2_w1");
        tik();
        getir_hazir_i         = 1'b0;
        getir_istek_gecerli_i = 1'b0;
        #1;
        chk("t2_adres_8", 64'(l1b_adres_o), 64'h8);
        tik();
        l1b_adres_kabul_i = 1'b0;
        l1b_gecerli_i     = 1'b1;
        l1b_buy_i         = 32'h0080_0193;
        bekle_it(32'h0080_0193, 32'h8);
        tik();
        l1b_gecerli_i = 1'b0;
        teslim_al("t2_w2");

        // ---- 3: flush with two requests in flight ----
        iki_istek("t3", 32'h100, 32'h104);
        bosalt_i = 1'b1;
        #1;
        chk("t3_bosalt_hazir", 64'(getir_istek_hazir_o), 64'd0);
        tik();
        bosalt_i              = 1'b0;
        getir_istek_gecerli_i = 1'b1;
        getir_ps_i            = 32'h200;
        l1b_gecerli_i         = 1'b1;
        l1b_buy_i             = 32'hBAD0_0001;
        #1;
        chk("t3_kredi_yok", 64'(getir_istek_hazir_o), 64'd0);
        tik();
        l1b_buy_i = 32'hBAD0_0002;
        #1;
        chk("t3_yeni_kabul", 64'(getir_istek_hazir_o), 64'd1);
        chk("t3_eski_atildi_1", 64'(getir_buy_gecerli_o), 64'd0);
        tik();
        getir_istek_gecerli_i = 1'b0;
        l1b_gecerli_i         = 1'b0;
        #1;
        chk("t3_eski_atildi_2", 64'(getir_buy_gecerli_o), 64'd0);
        chk("t3_adres_200", 64'({l1b_adres_gecerli_o, l1b_adres_o}), 64'h1_0000_0200);
        l1b_adres_kabul_i = 1'b1;
        tik();
        l1b_adres_kabul_i = 1'b0;
        tik();
        l1b_gecerli_i = 1'b1;
        l1b_buy_i     = 32'h2000_0013;
        bekle_it(32'h2000_0013, 32'h200);
        tik();
        l1b_gecerli_i = 1'b0;
        teslim_al("t3_yeni");

        // ---- 4: flush while the address is held ----
        getir_istek_gecerli_i = 1'b1;
        getir_ps_i            = 32'h302;
        #1;
        chk("t4_hazir", 64'(getir_istek_hazir_o), 64'd1);
        tik();
        getir_istek_gecerli_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) bosalt_i = 1'b1;
            #1;
            chk($sformatf("t4_adres_sabit_%0d", i),
                64'({l1b_adres_gecerli_o, l1b_adres_o}), 64'h1_0000_0300);
            chk($sformatf("t4_hazir_yok_%0d", i), 64'(getir_istek_hazir_o), 64'd0);
            tik();
            bosalt_i = 1'b0;
        end
        l1b_adres_kabul_i = 1'b1;
        #1;
        chk("t4_adres_kabulde", 64'({l1b_adres_gecerli_o, l1b_adres_o}), 64'h1_0000_0300);
        tik();
        l1b_adres_kabul_i = 1'b0;
        #1;
        chk("t4_adres_birakildi", 64'(l1b_adres_gecerli_o), 64'd0);
        l1b_gecerli_i = 1'b1;
        l1b_buy_i     = 32'hBAD0_0300;
        tik();
        l1b_gecerli_i = 1'b0;
        #1;
        chk("t4_kelime_atildi", 64'(getir_buy_gecerli_o), 64'd0);
        chk("t4_hata_yok", 64'(hata_o), 64'd0);

        // ---- 5: flush together with l1b_gecerli_i, one word buffered ----
        iki_istek("t5", 32'h400, 32'h404);
        l1b_gecerli_i = 1'b1;
        l1b_buy_i     = 32'h1111_0000;
        tik();
        #1;
        chk("t5_tamponda_bir", 64'(getir_buy_gecerli_o), 64'd1);
        bosalt_i  = 1'b1;
        l1b_buy_i = 32'h2222_0000;
        tik();
        bosalt_i      = 1'b0;
        l1b_gecerli_i = 1'b0;
        #1;
        chk("t5_temizlendi", 64'(getir_buy_gecerli_o), 64'd0);
        repeat (3) tik();
        chk("t5_teslim_yok", 64'(getir_buy_gecerli_o), 64'd0);
        chk("t5_hata_yok", 64'(hata_o), 64'd0);

        // ---- 6: spurious word at idle, sticky error, async clear ----
        chk("t6_once", 64'(hata_o), 64'd0);
        l1b_gecerli_i = 1'b1;
        l1b_buy_i     = 32'hDEAD_BEEF;
        tik();
        l1b_gecerli_i = 1'b0;
        #1;
        chk("t6_hata", 64'(hata_o), 64'd1);
        repeat (3) tik();
        chk("t6_kalici", 64'(hata_o), 64'd1);
        chk("t6_kelime_yok", 64'(getir_buy_gecerli_o), 64'd0);
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_asenkron_temiz", 64'(hata_o), 64'd0);
        chk("t6_sifirda_hazir", 64'(getir_istek_hazir_o), 64'd0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        tik();
        tik();
        chk("t6_sonra_hazir", 64'(getir_istek_hazir_o), 64'd1);
        chk("t6_sonra_hata", 64'(hata_o), 64'd0);

        chk("kuyruk_bos_sonda", 64'(beklenenler.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
